// File: rtl/program_loader_pkg.sv
// Shared constants for the instruction-memory loader.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Holds the default widths and the loader state encoding used by program_loader.
package program_loader_pkg;

  localparam int ADDR_WIDTH_DEF  = 8;   // matches the 8-bit program counter
  localparam int INSTR_WIDTH_DEF = 16;  // must be a multiple of 8

  // Loader states, kept as plain constants for legacy tool compatibility.
  localparam logic [2:0] ST_LEN   = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-RAM write port and load status of the loader.
// Latency: n/a (wiring only).
// Backpressure: rx_valid/rx_ready handshake; the source holds rx_data until rx_ready.
// Modports: master = loader side (drives rx_ready, mem_*, load_*),
//           slave  = byte source / RAM / PC side.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   reload;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_wdata;
  logic                   load_done;
  logic                   load_err;

  modport master (
    input  rx_data, rx_valid, reload,
    output rx_ready, mem_we, mem_addr, mem_wdata, load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid, reload,
    input  rx_ready, mem_we, mem_addr, mem_wdata, load_done, load_err
  );
endinterface

// File: rtl/program_loader_word_packer.sv
// Packs bytes MSB-first into one instruction word.
// Latency: word_ready_o/word_o are combinational with the final byte's shift strobe.
// Backpressure: none; the parent only shifts on an accepted byte.
// Ports: CLK, RST_N, clr_i (restart word), shift_i (byte accepted), byte_i,
//        word_ready_o (this shift completes a word), word_o (completed word).
module program_loader_word_packer #(
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   clr_i,
  input  logic                   shift_i,
  input  logic [7:0]             byte_i,
  output logic                   word_ready_o,
  output logic [INSTR_WIDTH-1:0] word_o
);
  localparam int BPW = INSTR_WIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [INSTR_WIDTH-1:0] sreg_q;
  logic [CW-1:0]          cnt_q;
  logic                   last;
  logic [INSTR_WIDTH-1:0] shifted;

  assign last         = (cnt_q == CW'(BPW - 1));
  // Shift written generically so an 8-bit word needs no special case.
  assign shifted      = (sreg_q << 8) | INSTR_WIDTH'(byte_i);
  assign word_ready_o = shift_i && last;
  assign word_o       = shifted;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (shift_i) begin
      sreg_q <= shifted;
      cnt_q  <= last ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte image into instruction RAM from address 0 and raises load_done.
// Latency: mem_we the cycle after a word's last byte; load_done the cycle after the final write.
// Backpressure: rx_ready low during WRITE, DONE, ERROR and reset; bytes are held by the source.
// Ports: CLK, RST_N (async, active low), bus (program_loader_if.master).
// Optional: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and load_err.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  program_loader_if.master bus
);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_FRAME_END = ST_CSUM;
`else
  localparam logic [2:0] ST_FRAME_END = ST_DONE;
`endif

  logic [2:0]             state_q, state_d;
  logic [7:0]             n_q, n_d;
  logic [ADDR_WIDTH-1:0]  widx_q, widx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   rdy_en_q;
  logic                   rx_rdy;
  logic                   xfer;
  logic                   word_rdy;
  logic [INSTR_WIDTH-1:0] word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  // rdy_en_q keeps rx_ready low while reset is asserted without a
  // combinational path from RST_N to the output.
  always_comb begin
    rx_rdy = 1'b0;
    if (rdy_en_q) begin
      rx_rdy = (state_q == ST_LEN) || (state_q == ST_RECV);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (state_q == ST_CSUM) rx_rdy = 1'b1;
`endif
    end
  end

  assign xfer = bus.rx_valid && rx_rdy;

  program_loader_word_packer #(.INSTR_WIDTH(INSTR_WIDTH)) u_packer (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .clr_i        (xfer && (state_q == ST_LEN)),
    .shift_i      (xfer && (state_q == ST_RECV)),
    .byte_i       (bus.rx_data),
    .word_ready_o (word_rdy),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_LEN: begin
        widx_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d = '0;
`endif
        if (xfer) begin
          n_d     = bus.rx_data;
          state_d = (bus.rx_data == 8'd0) ? ST_FRAME_END : ST_RECV;
        end
      end
      ST_RECV: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (xfer) csum_d = csum_q ^ bus.rx_data;
`endif
        // Capture address/data here so they stay stable outside the strobe.
        if (word_rdy) begin
          addr_d  = widx_q;
          wdata_d = word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        widx_d  = widx_q + 1'b1;
        // Compare in int width so N=255 never needs an address past 254.
        state_d = ((int'(widx_q) + 1) == int'(n_q)) ? ST_FRAME_END : ST_RECV;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERROR;
      end
      ST_ERROR: begin
        if (bus.reload) begin
          state_d = ST_LEN;
          widx_d  = '0;
        end
      end
`endif
      ST_DONE: begin
        if (bus.reload) begin
          state_d = ST_LEN;
          widx_d  = '0;
        end
      end
      default: state_d = ST_LEN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_LEN;
      n_q      <= '0;
      widx_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdy_en_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      widx_q   <= widx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdy_en_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_rdy;
  assign bus.mem_we    = (state_q == ST_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.load_done = (state_q == ST_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign bus.load_err  = (state_q == ST_ERROR);
`else
  assign bus.load_err  = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random and directed frames against a frame-level model.
// Latency: n/a.
// Backpressure: byte source holds each byte until rx_ready.
module tb_program_loader;
  localparam int IW  = 16;
  localparam int AW  = 8;
  localparam int BPW = IW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus();

  program_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          addr;
    logic [IW-1:0] data;
    int          c;
  } wr_t;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         acc_cyc     = 0;
  int         done_cyc    = -1;
  logic       prev_end    = 1'b0;
  wr_t        got[$];
  logic [7:0] pl[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write/end-of-load monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        got.push_back('{int'(bus.mem_addr), bus.mem_wdata, cyc});
        chk("rdy_low_in_write", 32'(bus.rx_ready), 32'd0);
      end
      if ((bus.load_done || bus.load_err) && !prev_end && done_cyc < 0) done_cyc = cyc;
      prev_end = bus.load_done || bus.load_err;
    end else begin
      prev_end = 1'b0;
    end
  end

  // Called on a falling edge; returns on a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit hold);
    int t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      chk("rx_accept_timeout", 32'(bus.rx_ready), 32'd1);
      bus.rx_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(negedge clk);
    if (!hold) begin
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic fill(input int n);
    pl.delete();
    for (int i = 0; i < n * BPW; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends one frame from pl and checks writes and end-of-load against the model.
  task automatic run_frame(input int n, input bit hold, input bit bad_csum);
    logic [7:0]    x = 8'h00;
    int            acc[$];
    int            len_c, end_c, t;
    bit            ok;
    logic [IW-1:0] w;
    got.delete();
    done_cyc = -1;
    send_byte(8'(n), hold);
    len_c = acc_cyc;
    for (int i = 0; i < n * BPW; i++) begin
      send_byte(pl[i], hold);
      x ^= pl[i];
      if ((i % BPW) == BPW - 1) acc.push_back(acc_cyc);
    end
    if (n == 0) end_c = len_c + 1;
    else        end_c = acc[n-1] + 2;
    ok = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, hold);
    end_c = acc_cyc + 1;
    ok    = !bad_csum;
`endif
    bus.rx_valid = 1'b0;
    t = 0;
    while (!(bus.load_done || bus.load_err) && t < 32) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("n_writes", 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      w = '0;
      for (int b = 0; b < BPW; b++) w = (w << 8) | IW'(pl[i*BPW + b]);
      chk("wr_addr", 32'(got[i].addr), 32'(i));
      chk("wr_data", 32'(got[i].data), 32'(w));
      chk("we_latency", 32'(got[i].c), 32'(acc[i] + 1));
    end
    chk("load_done", 32'(bus.load_done), 32'(ok));
    chk("load_err", 32'(bus.load_err), 32'(!ok));
    chk("end_latency", 32'(done_cyc), 32'(end_c));
  endtask

  task automatic reload_pulse();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
    chk("reload_done_clr", 32'(bus.load_done), 32'd0);
    chk("reload_err_clr", 32'(bus.load_err), 32'd0);
    chk("reload_rdy", 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({pfx, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({pfx, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({pfx, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({pfx, "_load_done"}, 32'(bus.load_done), 32'd0);
    chk({pfx, "_load_err"}, 32'(bus.load_err), 32'd0);
  endtask

  initial begin
    int stall;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.reload   = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed two-word frame.
    pl = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame(2, 1'b0, 1'b0);
    reload_pulse();

    // Empty image.
    pl.delete();
    run_frame(0, 1'b0, 1'b0);
    reload_pulse();

    // Random frames, alternating gapped and continuous valid.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 6);
      fill(n);
      run_frame(n, k[0], 1'b0);
      reload_pulse();
    end

    // Extra bytes in DONE stall, then reload and load again from address 0.
    fill(1);
    run_frame(1, 1'b1, 1'b0);
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    stall = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rx_ready) stall++;
    end
    chk("stall_in_done", 32'(stall), 32'd0);
    chk("done_held", 32'(bus.load_done), 32'd1);
    bus.rx_valid = 1'b0;
    reload_pulse();
    fill(2);
    run_frame(2, 1'b0, 1'b0);
    reload_pulse();

    // Reset after 3 bytes of a 4-word frame.
    send_byte(8'h04, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pl = '{8'hBE, 8'hEF};
    run_frame(1, 1'b0, 1'b0);
    reload_pulse();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // 0x12 ^ 0x34 = 0x26 accepted; 0x27 rejected.
    pl = '{8'h12, 8'h34};
    run_frame(1, 1'b0, 1'b0);
    reload_pulse();
    run_frame(1, 1'b0, 1'b1);
    reload_pulse();
`endif

    // Largest image: addresses 0..254, 255 left unwritten.
    fill(255);
    run_frame(255, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
